// File: rtl/program_loader_if.sv
// Byte-stream and program-memory signals between a stream source and the program loader.
interface program_loader_if;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        MemWrite;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        CPUResetN;
    logic        Busy;
    logic        Done;
    logic        Error;

    modport master (
        output Start, ByteIn, ByteValid,
        input  ByteReady, MemWrite, WriteAddress, WriteData, CPUResetN, Busy, Done, Error
    );

    modport slave (
        input  Start, ByteIn, ByteValid,
        output ByteReady, MemWrite, WriteAddress, WriteData, CPUResetN, Busy, Done, Error
    );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory,
// then releases the core from reset.
//
// state  | meaning
// IDLE   | waiting for Start, core held in reset
// LEN_LO | expecting low byte of word count
// LEN_HI | expecting high byte of word count, range-checked against memory depth
// DATA   | assembling little-endian words, one write strobe per completed word
// CHECK  | expecting checksum byte
// DONE   | image good, core released
// ERROR  | oversize header or bad checksum, core held in reset
module program_loader #(
    parameter int          MEMORY_DEPTH = 256,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input logic             clk,
    input logic             reset,
    program_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(MEMORY_DEPTH);

    state_t      state, next_state;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [15:0] hdr_len;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic [23:0] shift;
    logic        mem_write;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        in_load;
    logic        accept;
    logic        last_word;
    logic        start_load;

    assign in_load    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CHECK);
    assign accept     = bus.ByteValid && in_load;
    assign hdr_len    = {bus.ByteIn, len[7:0]};
    assign last_word  = (word_cnt == len - 16'd1);
    assign start_load = bus.Start &&
                        ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

    // Status flags decode straight from the registered state.
    assign bus.ByteReady    = in_load;
    assign bus.Busy         = in_load;
    assign bus.Done         = (state == S_DONE);
    assign bus.Error        = (state == S_ERROR);
    assign bus.CPUResetN    = (state == S_DONE);
    assign bus.MemWrite     = mem_write;
    assign bus.WriteAddress = wr_addr;
    assign bus.WriteData    = wr_data;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (bus.Start) next_state = S_LEN_LO;
            S_LEN_LO: if (accept) next_state = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (hdr_len > DEPTH_W)    next_state = S_ERROR;
                    else if (hdr_len == 16'd0) next_state = S_CHECK;
                    else                       next_state = S_DATA;
                end
            end
            S_DATA: if (accept && byte_cnt == 2'd3 && last_word) next_state = S_CHECK;
            S_CHECK: if (accept) next_state = (bus.ByteIn == csum) ? S_DONE : S_ERROR;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            csum      <= '0;
            shift     <= '0;
            mem_write <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            mem_write <= 1'b0;
            if (start_load) begin
                csum     <= '0;
                word_cnt <= '0;
                byte_cnt <= '0;
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: begin
                        len[7:0] <= bus.ByteIn;
                        csum     <= csum ^ bus.ByteIn;
                    end
                    S_LEN_HI: begin
                        len[15:8] <= bus.ByteIn;
                        csum      <= csum ^ bus.ByteIn;
                    end
                    S_DATA: begin
                        csum     <= csum ^ bus.ByteIn;
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {bus.ByteIn, shift[23:8]};
                        // Fourth byte completes the word; strobe it on the following cycle.
                        if (byte_cnt == 2'd3) begin
                            mem_write <= 1'b1;
                            wr_addr   <= BASE_ADDRESS + {14'd0, word_cnt, 2'b00};
                            wr_data   <= {bus.ByteIn, shift};
                            word_cnt  <= word_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: streams images and checks writes, status and core reset.
module tb_program_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    program_loader_if bus();

    program_loader #(.MEMORY_DEPTH(256), .BASE_ADDRESS(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          stalls   = 0;
    bit          both_seen = 1'b0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stream[$];

    always @(negedge clk) begin
        if (bus.MemWrite === 1'b1) begin
            wr_addr.push_back(bus.WriteAddress);
            wr_data.push_back(bus.WriteData);
        end
        if (bus.Done === 1'b1 && bus.Error === 1'b1) both_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [7:0] b);
        int t = 0;
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        while (bus.ByteReady !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) begin
            n_checks++;
            $display("FAIL send_timeout: ByteReady=%b, required 1", bus.ByteReady);
        end
        stalls += t;
        @(negedge clk);
    endtask

    task automatic send_stream(input int gap, input int poke_idx);
        for (int i = 0; i < stream.size(); i++) begin
            send(stream[i]);
            if (gap > 0) begin
                bus.ByteValid = 1'b0;
                bus.ByteIn    = 8'h5A;
                if (i == poke_idx) bus.Start = 1'b1;
                repeat (gap) @(negedge clk);
                bus.Start = 1'b0;
            end
        end
        bus.ByteValid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.ByteReady, bus.MemWrite, bus.WriteAddress, bus.WriteData, bus.CPUResetN,
             bus.Busy, bus.Done, bus.Error} !== 70'd0)
            $display("FAIL reset_outputs: rdy=%b mw=%b addr=%h data=%h rstn=%b busy=%b done=%b err=%b, required all 0",
                     bus.ByteReady, bus.MemWrite, bus.WriteAddress, bus.WriteData,
                     bus.CPUResetN, bus.Busy, bus.Done, bus.Error);
        else n_pass++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.ByteReady, bus.Busy, bus.CPUResetN} !== 3'b000)
            $display("FAIL idle_after_reset: rdy/busy/rstn=%b, required 000",
                     {bus.ByteReady, bus.Busy, bus.CPUResetN});
        else n_pass++;
    endtask

    task automatic test_single_word();
        int base = wr_addr.size();
        stream = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2C};
        pulse_start();
        n_checks++;
        if ({bus.Busy, bus.ByteReady, bus.Done} !== 3'b110)
            $display("FAIL start_busy: busy/rdy/done=%b, required 110", {bus.Busy, bus.ByteReady, bus.Done});
        else n_pass++;
        stalls = 0;
        send_stream(0, -1);
        n_checks++;
        if ({bus.Done, bus.CPUResetN, bus.Error, bus.Busy} !== 4'b1100)
            $display("FAIL single_status: done/rstn/err/busy=%b, required 1100",
                     {bus.Done, bus.CPUResetN, bus.Error, bus.Busy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_addr.size() != base + 1)
            $display("FAIL single_write_count: got %0d, required %0d", wr_addr.size() - base, 1);
        else begin
            n_pass++;
            n_checks++;
            if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h2008_0005)
                $display("FAIL single_write: addr=%h data=%h, required 00000000 20080005",
                         wr_addr[base], wr_data[base]);
            else n_pass++;
        end
        n_checks++;
        if (stalls != 0) $display("FAIL throughput_stalls: got %0d, required 0", stalls);
        else n_pass++;
    endtask

    task automatic test_toggle_valid();
        int base = wr_addr.size();
        stream = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h09, 8'h01, 8'h47};
        pulse_start();
        n_checks++;
        if ({bus.CPUResetN, bus.Done, bus.Busy} !== 3'b001)
            $display("FAIL restart_from_done: rstn/done/busy=%b, required 001",
                     {bus.CPUResetN, bus.Done, bus.Busy});
        else n_pass++;
        send_stream(1, 5);
        n_checks++;
        if ({bus.Done, bus.Error, bus.CPUResetN} !== 3'b101)
            $display("FAIL toggle_status: done/err/rstn=%b, required 101", {bus.Done, bus.Error, bus.CPUResetN});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_addr.size() != base + 2)
            $display("FAIL toggle_write_count: got %0d, required 2", wr_addr.size() - base);
        else begin
            n_pass++;
            n_checks++;
            if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h2008_0005 ||
                wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h0109_4020)
                $display("FAIL toggle_writes: %h:%h %h:%h, required 00000000:20080005 00000004:01094020",
                         wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
            else n_pass++;
        end
    endtask

    task automatic test_oversize();
        int base = wr_addr.size();
        stream = '{8'h01, 8'h01};
        pulse_start();
        send_stream(0, -1);
        n_checks++;
        if ({bus.Error, bus.Done, bus.ByteReady, bus.CPUResetN, bus.Busy} !== 5'b10000)
            $display("FAIL oversize_status: err/done/rdy/rstn/busy=%b, required 10000",
                     {bus.Error, bus.Done, bus.ByteReady, bus.CPUResetN, bus.Busy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_addr.size() != base) $display("FAIL oversize_writes: got %0d, required 0", wr_addr.size() - base);
        else n_pass++;
        stream = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2C};
        pulse_start();
        send_stream(0, -1);
        n_checks++;
        if ({bus.Done, bus.Error, bus.CPUResetN} !== 3'b101)
            $display("FAIL restart_from_error: done/err/rstn=%b, required 101", {bus.Done, bus.Error, bus.CPUResetN});
        else n_pass++;
    endtask

    task automatic test_bad_checksum();
        int base = wr_addr.size();
        stream = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2D};
        pulse_start();
        send_stream(0, -1);
        n_checks++;
        if ({bus.Error, bus.Done, bus.CPUResetN} !== 3'b100)
            $display("FAIL badsum_status: err/done/rstn=%b, required 100", {bus.Error, bus.Done, bus.CPUResetN});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_addr.size() != base + 1 || wr_data[wr_data.size()-1] !== 32'h2008_0005)
            $display("FAIL badsum_write: count=%0d, required 1 write of 20080005", wr_addr.size() - base);
        else n_pass++;
    endtask

    task automatic test_zero_length();
        int base = wr_addr.size();
        stream = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_stream(0, -1);
        n_checks++;
        if ({bus.Done, bus.Error, bus.CPUResetN} !== 3'b101)
            $display("FAIL zero_good: done/err/rstn=%b, required 101", {bus.Done, bus.Error, bus.CPUResetN});
        else n_pass++;
        stream = '{8'h00, 8'h00, 8'h01};
        pulse_start();
        send_stream(0, -1);
        n_checks++;
        if ({bus.Done, bus.Error, bus.CPUResetN} !== 3'b010)
            $display("FAIL zero_bad: done/err/rstn=%b, required 010", {bus.Done, bus.Error, bus.CPUResetN});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_addr.size() != base) $display("FAIL zero_writes: got %0d, required 0", wr_addr.size() - base);
        else n_pass++;
    endtask

    task automatic test_full_depth();
        int          base = wr_addr.size();
        int          bad = 0;
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        stream = '{8'h00, 8'h01};
        x = 8'h01;
        for (int k = 0; k < 256; k++) begin
            w = 32'h1000_0000 + k * 32'h0001_0003;
            for (int b = 0; b < 4; b++) begin
                stream.push_back(w[8*b +: 8]);
                x ^= w[8*b +: 8];
            end
        end
        stream.push_back(x);
        pulse_start();
        send_stream(0, -1);
        n_checks++;
        if ({bus.Done, bus.Error} !== 2'b10)
            $display("FAIL full_status: done/err=%b, required 10", {bus.Done, bus.Error});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_addr.size() != base + 256) $display("FAIL full_count: got %0d, required 256", wr_addr.size() - base);
        else begin
            n_pass++;
            for (int k = 0; k < 256; k++)
                if (wr_addr[base+k] !== 32'(4 * k) || wr_data[base+k] !== 32'h1000_0000 + k * 32'h0001_0003) bad++;
            n_checks++;
            if (bad != 0 || wr_addr[base+255] !== 32'h0000_03FC)
                $display("FAIL full_contents: %0d bad words, last addr=%h, required 0 and 000003fc",
                         bad, wr_addr[base+255]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_load();
        int base = wr_addr.size();
        stream = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40};
        pulse_start();
        send_stream(0, -1);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.ByteReady, bus.MemWrite, bus.WriteAddress, bus.WriteData, bus.CPUResetN,
             bus.Busy, bus.Done, bus.Error} !== 70'd0)
            $display("FAIL midload_reset_outputs: rdy=%b mw=%b addr=%h data=%h rstn=%b busy=%b, required all 0",
                     bus.ByteReady, bus.MemWrite, bus.WriteAddress, bus.WriteData, bus.CPUResetN, bus.Busy);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_addr.size() != base + 1) $display("FAIL midload_writes: got %0d, required 1", wr_addr.size() - base);
        else n_pass++;
        bus.ByteIn    = 8'hAA;
        bus.ByteValid = 1'b1;
        bus.Start     = 1'b1;
        n_checks++;
        if (bus.ByteReady !== 1'b0) $display("FAIL idle_ready: got %b, required 0", bus.ByteReady);
        else n_pass++;
        @(negedge clk);
        bus.Start = 1'b0;
        base = wr_addr.size();
        stream = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2C};
        send_stream(0, -1);
        n_checks++;
        if ({bus.Done, bus.Error, bus.CPUResetN} !== 3'b101)
            $display("FAIL reload_status: done/err/rstn=%b, required 101", {bus.Done, bus.Error, bus.CPUResetN});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_addr.size() != base + 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h2008_0005)
            $display("FAIL reload_write: count=%0d, required 1 write 00000000:20080005", wr_addr.size() - base);
        else n_pass++;
    endtask

    initial begin
        bus.Start     = 1'b0;
        bus.ByteIn    = 8'h00;
        bus.ByteValid = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_toggle_valid();
        test_oversize();
        test_bad_checksum();
        test_zero_length();
        test_full_depth();
        test_reset_mid_load();
        n_checks++;
        if (both_seen) $display("FAIL done_and_error: both seen high together, required never");
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
